// File: rtl/klein_pkg.sv
// Shared KLEIN definitions: widths, FSM encoding, key payload layout and the sbox table.
package klein_pkg;

    localparam int unsigned KLEIN_ROUNDS = 12;
    localparam int unsigned KLEIN_BLK_W  = 64;
    localparam int unsigned KLEIN_NIB_W  = 4;
    localparam int unsigned KLEIN_NIBS   = KLEIN_BLK_W / KLEIN_NIB_W;
    localparam int unsigned KLEIN_RND_W  = 4;
    localparam int unsigned KLEIN_COL_W  = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } klein_fsm_e;

    // Key register split into its two 32-bit tuples; a is the MSB half.
    typedef struct packed {
        logic [KLEIN_COL_W-1:0] a;
        logic [KLEIN_COL_W-1:0] b;
    } klein_key_t;

    // KLEIN 4-bit sbox (an involution, so encrypt and decrypt share it).
    function automatic logic [KLEIN_NIB_W-1:0] klein_sbox_f(input logic [KLEIN_NIB_W-1:0] x);
        logic [KLEIN_NIB_W-1:0] y;
        case (x)
            4'h0:    y = 4'h7;
            4'h1:    y = 4'h4;
            4'h2:    y = 4'hA;
            4'h3:    y = 4'h9;
            4'h4:    y = 4'h1;
            4'h5:    y = 4'hF;
            4'h6:    y = 4'hB;
            4'h7:    y = 4'h0;
            4'h8:    y = 4'hC;
            4'h9:    y = 4'h3;
            4'hA:    y = 4'h2;
            4'hB:    y = 4'h6;
            4'hC:    y = 4'h8;
            4'hD:    y = 4'hE;
            4'hE:    y = 4'hD;
            default: y = 4'h5;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/klein_keystep_fwd.sv
// One forward KLEIN key-schedule step: subkey i -> subkey i+1, with round counter i.
module klein_keystep_fwd
    import klein_pkg::*;
(
    input  logic [KLEIN_BLK_W-1:0] kstate,
    input  logic [KLEIN_RND_W-1:0] rnd,
    output logic [KLEIN_BLK_W-1:0] kstate_next
);

    klein_key_t             k;
    klein_key_t             pre;
    logic [KLEIN_COL_W-1:0] a_rot;
    logic [KLEIN_COL_W-1:0] b_rot;
    logic [15:0]            sub;

    assign k = klein_key_t'(kstate);

    // Rotate, swap/fold, then inject the round counter into byte 2 of the new left tuple.
    always_comb begin
        a_rot = {k.a[23:0], k.a[31:24]};
        b_rot = {k.b[23:0], k.b[31:24]};
        pre.a = b_rot ^ {16'd0, 4'd0, rnd, 8'd0};
        pre.b = a_rot ^ b_rot;
    end

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        klein_sbox u_sbox (
            .inib (pre.b[8+4*i +: KLEIN_NIB_W]),
            .onib (sub[4*i +: KLEIN_NIB_W])
        );
    end

    assign kstate_next = {pre.a, pre.b[31:24], sub, pre.b[7:0]};

endmodule

// File: rtl/klein_mixcolumn.sv
// AES MixColumn on one 32-bit column (byte 0 in the MSBs); iinv selects the inverse matrix.
module klein_mixcolumn
    import klein_pkg::*;
(
    input  logic [KLEIN_COL_W-1:0] icol,
    input  logic                   iinv,
    output logic [KLEIN_COL_W-1:0] ocol
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    logic [7:0] b   [4];
    logic [7:0] x2  [4];
    logic [7:0] x4  [4];
    logic [7:0] x8  [4];
    logic [7:0] m3  [4];
    logic [7:0] m9  [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [KLEIN_COL_W-1:0] fwd;
    logic [KLEIN_COL_W-1:0] inv;

    // Per-byte GF(2^8) multiples needed by both matrices.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            b[i]   = icol[KLEIN_COL_W-1-8*i -: 8];
            x2[i]  = xt(b[i]);
            x4[i]  = xt(x2[i]);
            x8[i]  = xt(x4[i]);
            m3[i]  = x2[i] ^ b[i];
            m9[i]  = x8[i] ^ b[i];
            m11[i] = x8[i] ^ x2[i] ^ b[i];
            m13[i] = x8[i] ^ x4[i] ^ b[i];
            m14[i] = x8[i] ^ x4[i] ^ x2[i];
        end
    end

    always_comb begin
        fwd = {x2[0] ^ m3[1] ^ b[2]  ^ b[3],
               b[0]  ^ x2[1] ^ m3[2] ^ b[3],
               b[0]  ^ b[1]  ^ x2[2] ^ m3[3],
               m3[0] ^ b[1]  ^ b[2]  ^ x2[3]};
        inv = {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
               m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
               m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
               m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
        ocol = iinv ? inv : fwd;
    end

endmodule

// File: rtl/klein_sbox.sv
// Single-nibble KLEIN substitution.
module klein_sbox
    import klein_pkg::*;
(
    input  logic [KLEIN_NIB_W-1:0] inib,
    output logic [KLEIN_NIB_W-1:0] onib
);

    assign onib = klein_sbox_f(inib);

endmodule

// File: rtl/klein_encipher.sv
// Iterative KLEIN block encryptor: one round per clock with the key schedule run alongside.
module klein_encipher
    import klein_pkg::*;
#(
    parameter int unsigned ROUNDS = KLEIN_ROUNDS
) (
    input  logic                   iclk,
    input  logic                   ireset,
    input  logic                   istart,
    input  logic [KLEIN_BLK_W-1:0] iblock,
    input  logic [KLEIN_BLK_W-1:0] ikey,
    output logic                   obusy,
    output logic                   oready,
    output logic [KLEIN_BLK_W-1:0] oblock
);

    localparam logic [KLEIN_RND_W-1:0] RND_LAST = KLEIN_RND_W'(ROUNDS);

    klein_fsm_e             st;
    klein_fsm_e             st_next;
    logic                   accept;
    logic                   last;
    logic [KLEIN_BLK_W-1:0] state_q;
    logic [KLEIN_BLK_W-1:0] kstate_q;
    logic [KLEIN_RND_W-1:0] rnd;

    logic [KLEIN_BLK_W-1:0] ark;
    logic [KLEIN_BLK_W-1:0] sub;
    logic [KLEIN_BLK_W-1:0] rot;
    logic [KLEIN_BLK_W-1:0] round_out;
    logic [KLEIN_BLK_W-1:0] key_next;

    // FSM state register.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            st <= ST_IDLE;
        end else begin
            st <= st_next;
        end
    end

    // Accept only from idle; the last round returns to idle.
    always_comb begin
        st_next = st;
        accept  = 1'b0;
        last    = 1'b0;
        case (st)
            ST_IDLE: begin
                if (istart) begin
                    accept  = 1'b1;
                    st_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rnd == RND_LAST) begin
                    last    = 1'b1;
                    st_next = ST_IDLE;
                end
            end
            default: st_next = ST_IDLE;
        endcase
    end

    assign obusy = (st == ST_RUN);

    assign ark = state_q ^ kstate_q;

    for (genvar i = 0; i < KLEIN_NIBS; i++) begin : g_sbox
        klein_sbox u_sbox (
            .inib (ark[KLEIN_NIB_W*i +: KLEIN_NIB_W]),
            .onib (sub[KLEIN_NIB_W*i +: KLEIN_NIB_W])
        );
    end

    assign rot = {sub[47:0], sub[63:48]};

    klein_mixcolumn u_mix_hi (
        .icol (rot[63:32]),
        .iinv (1'b0),
        .ocol (round_out[63:32])
    );

    klein_mixcolumn u_mix_lo (
        .icol (rot[31:0]),
        .iinv (1'b0),
        .ocol (round_out[31:0])
    );

    klein_keystep_fwd u_keystep (
        .kstate      (kstate_q),
        .rnd         (rnd),
        .kstate_next (key_next)
    );

    // Datapath and result registers; idle cycles leave everything untouched.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q  <= '0;
            kstate_q <= '0;
            rnd      <= '0;
            oblock   <= '0;
            oready   <= 1'b0;
        end else if (accept) begin
            state_q  <= iblock;
            kstate_q <= ikey;
            rnd      <= KLEIN_RND_W'(1);
            oready   <= 1'b0;
        end else if (obusy) begin
            state_q  <= round_out;
            kstate_q <= key_next;
            if (last) begin
                oblock <= round_out ^ key_next;
                oready <= 1'b1;
                rnd    <= '0;
            end else begin
                rnd <= rnd + KLEIN_RND_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_klein_encipher.sv
// Self-checking bench for klein_encipher: byte-level KLEIN reference model plus directed vectors.
module tb_klein_encipher;

    localparam int unsigned NR = 12;

    logic        iclk = 1'b0;
    logic        ireset = 1'b1;
    logic        istart = 1'b0;
    logic [63:0] iblock = '0;
    logic [63:0] ikey = '0;
    logic        obusy;
    logic        oready;
    logic [63:0] oblock;

    int checks = 0;
    int errors = 0;

    klein_encipher #(.ROUNDS(NR)) dut (
        .iclk   (iclk),
        .ireset (ireset),
        .istart (istart),
        .iblock (iblock),
        .ikey   (ikey),
        .obusy  (obusy),
        .oready (oready),
        .oblock (oblock)
    );

    always #5 iclk = ~iclk;

    localparam logic [3:0] SB [16] = '{4'h7, 4'h4, 4'hA, 4'h9, 4'h1, 4'hF, 4'hB, 4'h0,
                                       4'hC, 4'h3, 4'h2, 4'h6, 4'h8, 4'hE, 4'hD, 4'h5};

    function automatic logic [7:0] sb8(input logic [7:0] v);
        return {SB[v[7:4]], SB[v[3:0]]};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [63:0] klein_ref(input logic [63:0] pt, input logic [63:0] key, input int rounds);
        logic [7:0] s [8];
        logic [7:0] k [8];
        logic [7:0] t [8];
        logic [7:0] nk [8];
        logic [63:0] res;
        for (int j = 0; j < 8; j++) begin
            s[j] = pt[63-8*j -: 8];
            k[j] = key[63-8*j -: 8];
        end
        for (int r = 1; r <= rounds; r++) begin
            for (int j = 0; j < 8; j++) t[j] = sb8(s[j] ^ k[j]);
            for (int j = 0; j < 8; j++) s[j] = t[(j + 2) % 8];
            for (int c = 0; c < 8; c += 4) begin
                for (int j = 0; j < 4; j++) t[j] = s[c+j];
                s[c+0] = gmul(t[0], 8'd2) ^ gmul(t[1], 8'd3) ^ t[2] ^ t[3];
                s[c+1] = t[0] ^ gmul(t[1], 8'd2) ^ gmul(t[2], 8'd3) ^ t[3];
                s[c+2] = t[0] ^ t[1] ^ gmul(t[2], 8'd2) ^ gmul(t[3], 8'd3);
                s[c+3] = gmul(t[0], 8'd3) ^ t[1] ^ t[2] ^ gmul(t[3], 8'd2);
            end
            for (int j = 0; j < 4; j++) begin
                nk[j]   = k[4 + (j + 1) % 4];
                nk[4+j] = k[(j + 1) % 4] ^ k[4 + (j + 1) % 4];
            end
            nk[2] = nk[2] ^ 8'(r);
            nk[5] = sb8(nk[5]);
            nk[6] = sb8(nk[6]);
            k = nk;
        end
        for (int j = 0; j < 8; j++) res[63-8*j -: 8] = s[j] ^ k[j];
        return res;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Transaction-level expectation, updated at each clock edge from the sampled inputs.
    logic        exp_busy  = 1'b0;
    logic        exp_ready = 1'b0;
    logic [63:0] exp_block = '0;
    logic [63:0] pending   = '0;
    int          left      = 0;
    logic        cmp_en    = 1'b0;

    always @(posedge iclk) begin
        if (ireset) begin
            exp_busy  = 1'b0;
            exp_ready = 1'b0;
            exp_block = '0;
            left      = 0;
        end else if (!exp_busy && istart) begin
            exp_busy  = 1'b1;
            exp_ready = 1'b0;
            left      = NR;
            pending   = klein_ref(iblock, ikey, NR);
        end else if (exp_busy) begin
            left--;
            if (left == 0) begin
                exp_busy  = 1'b0;
                exp_ready = 1'b1;
                exp_block = pending;
            end
        end
    end

    always @(negedge iclk) begin
        if (cmp_en) begin
            check("obusy", 64'(obusy), 64'(exp_busy));
            check("oready", 64'(oready), 64'(exp_ready));
            check("oblock", oblock, exp_block);
            check("busy_and_ready", 64'(obusy & oready), 64'd0);
        end
    end

    task automatic run_vec(input string nm, input logic [63:0] pt, input logic [63:0] key,
                           input logic [63:0] want);
        int n;
        @(negedge iclk);
        istart = 1'b1;
        iblock = pt;
        ikey   = key;
        @(negedge iclk);
        istart = 1'b0;
        n = 0;
        while (!oready && n < 40) begin
            @(negedge iclk);
            n++;
        end
        check({nm, "_latency"}, 64'(n), 64'(NR));
        check({nm, "_result"}, oblock, want);
    endtask

    localparam logic [63:0] K1 = 64'h0000000000000000, P1 = 64'hFFFFFFFFFFFFFFFF, C1 = 64'hCDC0B51F14722BBE;
    localparam logic [63:0] K2 = 64'hFFFFFFFFFFFFFFFF, P2 = 64'h0000000000000000, C2 = 64'h6456764E8602E154;
    localparam logic [63:0] K3 = 64'h1234567890ABCDEF, P3 = 64'hFFFFFFFFFFFFFFFF, C3 = 64'h592356C4997176C8;
    localparam logic [63:0] K4 = 64'h0000000000000000, P4 = 64'h1234567890ABCDEF, C4 = 64'h629F9D6DFF95800E;

    initial begin
        int rise [3];
        int nr;
        int n;
        logic prev;

        // Pin the reference model to the published vectors.
        check("model_T1", klein_ref(P1, K1, NR), C1);
        check("model_T2", klein_ref(P2, K2, NR), C2);
        check("model_T3", klein_ref(P3, K3, NR), C3);
        check("model_T4", klein_ref(P4, K4, NR), C4);

        repeat (2) @(negedge iclk);
        ireset = 1'b0;
        cmp_en = 1'b1;
        check("reset_obusy", 64'(obusy), 64'd0);
        check("reset_oblock", oblock, 64'd0);

        run_vec("T1", P1, K1, C1);
        run_vec("T2", P2, K2, C2);
        run_vec("T3", P3, K3, C3);
        run_vec("T4", P4, K4, C4);

        // T5: start pulses during a run are ignored.
        @(negedge iclk);
        istart = 1'b1;
        iblock = P1;
        ikey   = K1;
        @(negedge iclk);
        istart = 1'b0;
        for (int c = 1; c <= int'(NR); c++) begin
            istart = (c == 3 || c == 7);
            iblock = P4;
            ikey   = K2;
            @(negedge iclk);
            if (c < int'(NR)) check("T5_no_early_ready", 64'(oready), 64'd0);
        end
        istart = 1'b0;
        check("T5_ready", 64'(oready), 64'd1);
        check("T5_result", oblock, C1);

        // T6: reset mid-run clears everything, then a fresh run is correct.
        @(negedge iclk);
        istart = 1'b1;
        iblock = P3;
        ikey   = K3;
        @(negedge iclk);
        istart = 1'b0;
        repeat (6) @(negedge iclk);
        ireset = 1'b1;
        @(negedge iclk);
        ireset = 1'b0;
        check("T6_rst_obusy", 64'(obusy), 64'd0);
        check("T6_rst_oready", 64'(oready), 64'd0);
        check("T6_rst_oblock", oblock, 64'd0);
        run_vec("T6_after_reset", P2, K2, C2);

        // Held start: back-to-back runs, one result every NR+1 edges.
        @(negedge iclk);
        istart = 1'b1;
        iblock = P3;
        ikey   = K3;
        nr   = 0;
        prev = oready;
        for (int c = 0; c < 80 && nr < 3; c++) begin
            @(negedge iclk);
            if (oready && !prev) begin
                rise[nr] = c;
                nr++;
            end
            prev = oready;
        end
        istart = 1'b0;
        check("T6_held_runs", 64'(nr), 64'd3);
        if (nr == 3) begin
            check("T6_held_gap1", 64'(rise[1] - rise[0]), 64'(NR + 1));
            check("T6_held_gap2", 64'(rise[2] - rise[1]), 64'(NR + 1));
            check("T6_held_result", oblock, C3);
        end
        n = 0;
        while (obusy && n < 20) begin
            @(negedge iclk);
            n++;
        end
        check("T6_final_idle", 64'(obusy), 64'd0);
        repeat (3) @(negedge iclk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
